wifi_conv_encoder: RTL and testbench
====================================

// Module: wifi_conv_encoder
// PURPOSE
//  Bit-serial 802.11a convolutional encoder (K=7, generators 133/171 octal) with puncturing.
//  Consumes the data_out/valid_out bit stream of the PHY input bit FIFO.
//  Emits up to 2 coded bits per cycle with a per-bit valid mask, for the interleaver stage.
//  Appends the 6 zero tail bits at frame end and pulses done when the tail is complete.
// PARAMETERS
//  TAIL_LEN  6  number of zero tail bits flushed after frame_end (must be >= 1; 6 for 802.11a)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-low reset
//  rate       in   2  00=1/2, 01=2/3, 10=3/4, 11=treated as 1/2; sampled at frame start only
//  valid_in   in   1  data_in is a valid uncoded bit this cycle
//  data_in    in   1  uncoded bit
//  frame_end  in   1  one-cycle pulse, concurrent with or after the last valid_in of the frame
//  data_out   out  2  [0]=coded bit A (g0=133), [1]=coded bit B (g1=171)
//  valid_out  out  2  per-bit valid mask for data_out; A is emitted before B when both valid
//  busy       out  1  high in RUN and TAIL
//  done       out  1  one-cycle pulse after the last tail bit is emitted
// BEHAVIOUR
//  Reset: data_out=0, valid_out=0, busy=0, done=0, shift register=0, puncture counter=0, state IDLE.
//  Shift register d1..d6: dk = encoder input bit k accepted inputs ago. Advances only on an accepted bit.
//  Coded bits for input b: A = b^d2^d3^d5^d6; B = b^d1^d2^d3^d6.
//  Latency: outputs registered, valid 1 cycle after the accepted input. valid_out=00 on all other cycles.
//  No backpressure: every valid_in in IDLE/RUN is accepted. Gaps in valid_in are allowed.
//  Puncturing, with pc = puncture counter, advancing per accepted bit (including tail bits):
//   1/2: mask 11 always. pc is held at 0.
//   2/3: pc mod 2. pc0 -> 11, pc1 -> 01 (A only).
//   3/4: pc mod 3. pc0 -> 11, pc1 -> 01, pc2 -> 10 (B only).
//  States:
//   IDLE: busy=0. A valid_in latches rate, encodes the bit with pc=0, and goes to RUN.
//         frame_end alone in IDLE is ignored.
//   RUN:  encode each valid_in. On frame_end go to TAIL; a valid_in in the same cycle is encoded first.
//   TAIL: feed TAIL_LEN zero bits on consecutive cycles, punctured as above. valid_in is ignored
//         (and dropped). After the last tail bit go to DONE.
//   DONE: single cycle. done=1, busy=0. Clear the shift register and pc. Go to IDLE.
//  valid_in in DONE: accepted as the first bit of a new frame (rate latched, pc=0), next state RUN.
//   The done pulse is still issued.
//  rate changes mid-frame have no effect until the next frame start.
//  Asynchronous reset mid-frame: the frame is aborted immediately with all reset values.
//   No done pulse and no tail.
//  All arithmetic is XOR over single bits. pc is 2 bits and wraps per rate modulus; pc never reaches 3.
// TESTING
//  Impulse, rate 1/2: bits 1,0,0,0,0,0 then frame_end -> A seq 1,0,1,1,0,1,1,...; B seq 1,1,1,1,0,0,1,...
//   Then 6 tail pairs of 00, done one cycle after the last tail pair.
//  Rate 3/4, 6 ones with gaps -> valid_out masks 11,01,10,11,01,10.
//   Gaps yield valid_out=00 and do not advance pc.
//  Rate 2/3, 3 bits then frame_end -> masks 11,01,11 then tail masks 01,11,01,11,01,11.
//   busy high throughout, done pulse once.
//  rate changed 01->10 mid-frame -> puncturing stays 2/3 until after done; next frame uses 3/4 from pc=0.
//  Reset asserted in TAIL at tail bit 3 -> all outputs 0 next edge, no done, next frame encodes from zero state.
//  valid_in concurrent with frame_end, and valid_in during TAIL -> first encoded, second dropped.
//   The tail bit count is exactly TAIL_LEN.

Source files
------------

// File: rtl/wifi_conv_encoder.sv
// Bit-serial 802.11a convolutional encoder (K=7, g0=133, g1=171) with 2/3 and 3/4 puncturing.
// Coded bits are registered one cycle after acceptance; there is no backpressure and every valid bit is taken.
module wifi_conv_encoder #(
   parameter int TAIL_LEN = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] rate,
   input  logic       valid_in,
   input  logic       data_in,
   input  logic       frame_end,
   output logic [1:0] data_out,
   output logic [1:0] valid_out,
   output logic       busy,
   output logic       done
);

   localparam int TW = $clog2(TAIL_LEN + 1);

   typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

   state_t         state, state_nxt;
   logic [6:1]     sr, sr_nxt, sr_cur;
   logic [1:0]     pc, pc_nxt, pc_adv;
   logic [1:0]     rate_q, rate_nxt;
   logic [TW-1:0]  tail_cnt, tail_nxt;
   logic           enc_en, enc_bit, coded_a, coded_b;
   logic [1:0]     enc_rate, enc_pc, mask;

   always_comb begin
      state_nxt = state;
      rate_nxt  = rate_q;
      tail_nxt  = tail_cnt;
      enc_en    = 1'b0;
      enc_bit   = 1'b0;
      enc_rate  = rate_q;
      enc_pc    = pc;
      sr_cur    = sr;

      case (state)
         IDLE: begin
            if (valid_in) begin
               enc_en    = 1'b1;
               enc_bit   = data_in;
               enc_rate  = rate;
               enc_pc    = 2'd0;
               rate_nxt  = rate;
               state_nxt = frame_end ? TAIL : RUN;
               tail_nxt  = '0;
            end
         end
         RUN: begin
            if (valid_in) begin
               enc_en  = 1'b1;
               enc_bit = data_in;
            end
            if (frame_end) begin
               state_nxt = TAIL;
               tail_nxt  = '0;
            end
         end
         TAIL: begin
            // valid_in is deliberately ignored here; the encoder is flushing zeros
            enc_en   = 1'b1;
            tail_nxt = tail_cnt + 1'b1;
            if (tail_cnt == TW'(TAIL_LEN - 1))
               state_nxt = DONE;
         end
         default: begin
            // DONE: encoder state is cleared, but a new frame may start in the same cycle
            sr_cur    = '0;
            enc_pc    = 2'd0;
            state_nxt = IDLE;
            if (valid_in) begin
               enc_en    = 1'b1;
               enc_bit   = data_in;
               enc_rate  = rate;
               rate_nxt  = rate;
               state_nxt = frame_end ? TAIL : RUN;
               tail_nxt  = '0;
            end
         end
      endcase

      coded_a = enc_bit ^ sr_cur[2] ^ sr_cur[3] ^ sr_cur[5] ^ sr_cur[6];
      coded_b = enc_bit ^ sr_cur[1] ^ sr_cur[2] ^ sr_cur[3] ^ sr_cur[6];

      case (enc_rate)
         2'b01: begin
            mask   = enc_pc[0] ? 2'b01 : 2'b11;
            pc_adv = {1'b0, ~enc_pc[0]};
         end
         2'b10: begin
            case (enc_pc)
               2'd0:    begin mask = 2'b11; pc_adv = 2'd1; end
               2'd1:    begin mask = 2'b01; pc_adv = 2'd2; end
               default: begin mask = 2'b10; pc_adv = 2'd0; end
            endcase
         end
         default: begin
            mask   = 2'b11;
            pc_adv = 2'd0;
         end
      endcase

      sr_nxt = enc_en ? {sr_cur[5:1], enc_bit} : sr_cur;
      pc_nxt = enc_en ? pc_adv : enc_pc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         sr        <= '0;
         pc        <= 2'd0;
         rate_q    <= 2'd0;
         tail_cnt  <= '0;
         data_out  <= 2'b00;
         valid_out <= 2'b00;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         sr        <= sr_nxt;
         pc        <= pc_nxt;
         rate_q    <= rate_nxt;
         tail_cnt  <= tail_nxt;
         data_out  <= enc_en ? ({coded_b, coded_a} & mask) : 2'b00;
         valid_out <= enc_en ? mask : 2'b00;
         done      <= (state == DONE);
      end
   end

   assign busy = (state == RUN) || (state == TAIL);

endmodule

// File: tb/tb_wifi_conv_encoder.sv
// Directed bench for wifi_conv_encoder with hand-computed coded bits and puncture masks.
module tb_wifi_conv_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] rate;
   logic       valid_in, data_in, frame_end;
   logic [1:0] data_out, valid_out;
   logic       busy, done;

   int n_cmp = 0;
   int n_err = 0;

   logic [1:0] em [6];
   logic [1:0] ed [6];

   wifi_conv_encoder #(.TAIL_LEN(6)) dut (
      .clk(clk), .reset(reset), .rate(rate), .valid_in(valid_in), .data_in(data_in),
      .frame_end(frame_end), .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one cycle of input; on return the registered result of that input is visible
   task automatic cyc(input logic v, input logic d, input logic f);
      valid_in  = v;
      data_in   = d;
      frame_end = f;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [1:0] vo, input logic [1:0] dat);
      chk({tag, "_vld"}, {2'b00, valid_out}, {2'b00, vo});
      chk({tag, "_dat"}, {2'b00, data_out}, {2'b00, dat});
   endtask

   initial begin
      reset = 1'b0; rate = 2'b00; valid_in = 1'b0; data_in = 1'b0; frame_end = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_vo", {2'b00, valid_out}, 4'h0);
      chk("rst_do", {2'b00, data_out}, 4'h0);
      chk("rst_busy", {3'b000, busy}, 4'h0);
      chk("rst_done", {3'b000, done}, 4'h0);
      reset = 1'b1;

      // frame_end alone in IDLE is ignored
      cyc(0, 0, 1);
      chk("idle_fe_busy", {3'b000, busy}, 4'h0);
      chk_out("idle_fe", 2'b00, 2'b00);

      // impulse at rate 1/2: {B,A} = 11,10,11,11,00,01,11
      rate = 2'b00;
      cyc(1, 1, 0); chk_out("imp0", 2'b11, 2'b11); chk("imp_busy", {3'b000, busy}, 4'h1);
      cyc(1, 0, 0); chk_out("imp1", 2'b11, 2'b10);
      cyc(1, 0, 0); chk_out("imp2", 2'b11, 2'b11);
      cyc(1, 0, 0); chk_out("imp3", 2'b11, 2'b11);
      cyc(1, 0, 0); chk_out("imp4", 2'b11, 2'b00);
      cyc(1, 0, 0); chk_out("imp5", 2'b11, 2'b01);
      cyc(1, 0, 1); chk_out("imp6", 2'b11, 2'b11);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0);
         chk_out("imp_tail", 2'b11, 2'b00);
         chk("imp_tail_done", {3'b000, done}, 4'h0);
      end
      chk("imp_busy_end", {3'b000, busy}, 4'h0);
      cyc(0, 0, 0);
      chk("imp_done", {3'b000, done}, 4'h1);
      chk_out("imp_done", 2'b00, 2'b00);
      cyc(0, 0, 0);
      chk("imp_done_off", {3'b000, done}, 4'h0);

      // rate 3/4, six ones with gaps; a valid_in during TAIL is dropped
      rate = 2'b10;
      cyc(1, 1, 0); chk_out("r34_0", 2'b11, 2'b11);
      cyc(0, 0, 0); chk_out("r34_gap", 2'b00, 2'b00);
      cyc(1, 1, 0); chk_out("r34_1", 2'b01, 2'b01);
      cyc(1, 1, 0); chk_out("r34_2", 2'b10, 2'b10);
      cyc(0, 0, 0); chk_out("r34_gap2", 2'b00, 2'b00);
      cyc(1, 1, 0); chk_out("r34_3", 2'b11, 2'b01);
      cyc(1, 1, 0); chk_out("r34_4", 2'b01, 2'b01);
      cyc(1, 1, 1); chk_out("r34_5", 2'b10, 2'b00);
      em = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
      ed = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10};
      for (int i = 0; i < 6; i++) begin
         if (i == 1) cyc(1, 1, 0);
         else        cyc(0, 0, 0);
         chk_out("r34_tail", em[i], ed[i]);
      end
      cyc(0, 0, 0);
      chk("r34_done", {3'b000, done}, 4'h1);
      chk_out("r34_after", 2'b00, 2'b00);
      cyc(0, 0, 0);

      // rate 2/3, rate changed to 3/4 mid-frame has no effect
      rate = 2'b01;
      cyc(1, 1, 0); chk_out("r23_0", 2'b11, 2'b11);
      rate = 2'b10;
      cyc(1, 0, 0); chk_out("r23_1", 2'b01, 2'b00);
      cyc(1, 1, 0); chk_out("r23_2", 2'b11, 2'b00);
      cyc(0, 0, 1); chk_out("r23_fe", 2'b00, 2'b00);
      em = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11};
      ed = '{2'b01, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11};
      for (int i = 0; i < 6; i++) begin
         chk("r23_busy", {3'b000, busy}, 4'h1);
         cyc(0, 0, 0);
         chk_out("r23_tail", em[i], ed[i]);
      end

      // valid_in in DONE starts a new frame at 3/4 from pc=0; done still pulses
      cyc(1, 1, 0);
      chk("r23_done", {3'b000, done}, 4'h1);
      chk_out("nf_0", 2'b11, 2'b11);
      cyc(1, 1, 0); chk_out("nf_1", 2'b01, 2'b01);
      chk("nf_done_off", {3'b000, done}, 4'h0);
      cyc(1, 1, 0); chk_out("nf_2", 2'b10, 2'b10);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      // asynchronous reset during tail bit 3
      #2 reset = 1'b0;
      #1;
      chk_out("arst", 2'b00, 2'b00);
      chk("arst_busy", {3'b000, busy}, 4'h0);
      chk("arst_done", {3'b000, done}, 4'h0);
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0);
         chk("arst_nodone", {3'b000, done}, 4'h0);
         chk_out("arst_idle", 2'b00, 2'b00);
      end

      // encoder restarts from zero state at rate 1/2
      rate = 2'b00;
      cyc(1, 1, 0); chk_out("post_0", 2'b11, 2'b11);
      cyc(1, 0, 0); chk_out("post_1", 2'b11, 2'b10);
      cyc(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
